// File: rtl/mips_pipe_pkg.sv
// ============================================================================
// Module  : mips_pipe_pkg
// Brief   : Shared types and widths for the MIPS EX/MEM pipeline boundary.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  dest_reg;
        ex_mem_ctrl_t      ctrl;
    } ex_mem_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/ex_mem_entry_reg.sv
// ============================================================================
// Module  : ex_mem_entry_reg
// Brief   : One EX/MEM payload slot with load enable and async reset.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_entry_reg
    import mips_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  ex_mem_payload_t i_d,
    output ex_mem_payload_t o_q
);

    ex_mem_payload_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_skid_reg.sv
// ============================================================================
// Module  : ex_mem_skid_reg
// Brief   : EX/MEM pipeline register built as a two-entry skid buffer with a
//           registered in_ready and synchronous flush. Optional stall counter
//           enabled by defining EX_MEM_PERF_CNT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_dest_reg,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_mem_to_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_dest_reg,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    import mips_pipe_pkg::*;

    skid_state_t     r_state;
    skid_state_t     w_state_nxt;
    logic            r_in_ready;
    logic            w_accept;
    logic            w_drain;
    logic            w_out_valid;
    logic            w_load_main;
    logic            w_load_skid;
    ex_mem_payload_t w_in_payload;
    ex_mem_payload_t w_main_d;
    ex_mem_payload_t r_main;
    ex_mem_payload_t r_skid;

    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = in_valid & r_in_ready;
    assign w_drain     = w_out_valid & out_ready;

    // Writes to $zero are architecturally dead, so drop RegWrite at capture.
    always_comb begin
        w_in_payload.alu_result      = in_alu_result;
        w_in_payload.store_data      = in_store_data;
        w_in_payload.dest_reg        = in_dest_reg;
        w_in_payload.ctrl.reg_write  = in_reg_write & (in_dest_reg != '0);
        w_in_payload.ctrl.mem_read   = in_mem_read;
        w_in_payload.ctrl.mem_write  = in_mem_write;
        w_in_payload.ctrl.mem_to_reg = in_mem_to_reg;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_load_main = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_drain) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = FULL;
                    w_load_skid = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_drain) begin
                    w_state_nxt = ONE;
                    w_load_main = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Squash wins over everything; anything arriving this cycle is lost.
        if (flush) begin
            w_state_nxt = EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
        end
    end

    assign w_main_d = (r_state == FULL) ? r_skid : w_in_payload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    ex_mem_entry_reg u_main (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_main),
        .i_d    (w_main_d),
        .o_q    (r_main)
    );

    ex_mem_entry_reg u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_skid),
        .i_d    (w_in_payload),
        .o_q    (r_skid)
    );

    assign in_ready       = r_in_ready;
    assign out_valid      = w_out_valid;
    assign out_alu_result = r_main.alu_result;
    assign out_store_data = r_main.store_data;
    assign out_dest_reg   = r_main.dest_reg;
    assign out_reg_write  = r_main.ctrl.reg_write & w_out_valid;
    assign out_mem_read   = r_main.ctrl.mem_read  & w_out_valid;
    assign out_mem_write  = r_main.ctrl.mem_write & w_out_valid;
    assign out_mem_to_reg = r_main.ctrl.mem_to_reg;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_skid_reg.sv
// ============================================================================
// Module  : tb_ex_mem_skid_reg
// Brief   : Scoreboard bench for ex_mem_skid_reg (directed + random traffic).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_dest_reg;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_mem_to_reg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_dest_reg;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_mem_to_reg;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] exp_stall = '0;
`endif

    int checks = 0;
    int errors = 0;
    logic [95:0] sb_q[$];

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_dest_reg    (in_dest_reg),
        .in_reg_write   (in_reg_write),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_dest_reg   (out_dest_reg),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_mem_to_reg (out_mem_to_reg)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] pack_out();
        return {23'd0, out_alu_result, out_store_data, out_dest_reg,
                out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg};
    endfunction

    function automatic logic [95:0] pack_in();
        return {23'd0, in_alu_result, in_store_data, in_dest_reg,
                in_reg_write & (in_dest_reg != 5'd0), in_mem_read, in_mem_write, in_mem_to_reg};
    endfunction

    // Reference model: queue occupancy mirrors EMPTY/ONE/FULL.
    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check_eq("sb_unexpected_out", 96'd1, 96'd0);
                else check_eq("sb_data", pack_out(), sb_q.pop_front());
            end
`ifdef EX_MEM_PERF_CNT_EN
            if (out_valid && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
`endif
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(pack_in());
        end
    end

    always @(posedge rst) begin
        sb_q.delete();
`ifdef EX_MEM_PERF_CNT_EN
        exp_stall = '0;
`endif
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("mon_out_valid", {95'd0, out_valid}, {95'd0, sb_q.size() != 0});
            check_eq("mon_in_ready", {95'd0, in_ready}, {95'd0, sb_q.size() < 2});
            if (!out_valid)
                check_eq("mon_gating", {93'd0, out_reg_write, out_mem_read, out_mem_write}, 96'd0);
`ifdef EX_MEM_PERF_CNT_EN
            check_eq("mon_stall_cycles", {64'd0, stall_cycles}, {64'd0, exp_stall});
`endif
        end
    end

    task automatic send(input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] dest, input logic [3:0] ctrl);
        int n = 0;
        in_valid      = 1'b1;
        in_alu_result = alu;
        in_store_data = sd;
        in_dest_reg   = dest;
        {in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg} = ctrl;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("send_timeout", 96'd0, 96'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        int n = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_done", {64'd0, sb_q.size()}, 96'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, {95'd0, in_ready}, 96'd1);
        check_eq({tag, "_out_valid"}, {95'd0, out_valid}, 96'd0);
        check_eq({tag, "_payload"}, pack_out(), 96'd0);
`ifdef EX_MEM_PERF_CNT_EN
        check_eq({tag, "_stall"}, {64'd0, stall_cycles}, 96'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_alu_result = '0; in_store_data = '0; in_dest_reg = '0;
        {in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg} = 4'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single pass with 1-cycle latency
        out_ready = 1'b1;
        send(32'h10, 32'h0, 5'd2, 4'b1000);
        check_eq("single_valid", {95'd0, out_valid}, 96'd1);
        check_eq("single_dest", {91'd0, out_dest_reg}, 96'd2);
        check_eq("single_alu", {64'd0, out_alu_result}, 96'h10);
        check_eq("single_rw", {95'd0, out_reg_write}, 96'd1);
        @(negedge clk);

        // Back-pressure: A, B fill the buffer, C held off
        out_ready = 1'b0;
        send(32'hA0, 32'hAAAA, 5'd1, 4'b1010);
        send(32'hB0, 32'hBBBB, 5'd2, 4'b0101);
        check_eq("bp_in_ready", {95'd0, in_ready}, 96'd0);
        check_eq("bp_head_dest", {91'd0, out_dest_reg}, 96'd1);
        in_valid = 1'b1; in_alu_result = 32'hC0; in_store_data = 32'hCCCC; in_dest_reg = 5'd3;
        repeat (2) @(negedge clk);
        check_eq("bp_held_in_ready", {95'd0, in_ready}, 96'd0);
        check_eq("bp_held_head", {64'd0, out_alu_result}, 96'hA0);
        out_ready = 1'b1;
        send(32'hC0, 32'hCCCC, 5'd3, 4'b1001);
        drain_wait();

        // $zero destination
        send(32'h55, 32'h66, 5'd0, 4'b1100);
        check_eq("zero_rw", {95'd0, out_reg_write}, 96'd0);
        check_eq("zero_dest", {91'd0, out_dest_reg}, 96'd0);
        check_eq("zero_mr", {95'd0, out_mem_read}, 96'd1);
        drain_wait();

        // Flush while FULL with an incoming entry
        out_ready = 1'b0;
        send(32'h111, 32'h1, 5'd4, 4'b1000);
        send(32'h222, 32'h2, 5'd5, 4'b1000);
        in_valid = 1'b1; in_alu_result = 32'hDEAD; in_dest_reg = 5'd6;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_out_valid", {95'd0, out_valid}, 96'd0);
        check_eq("flush_in_ready", {95'd0, in_ready}, 96'd1);
        out_ready = 1'b1;
        send(32'h333, 32'h3, 5'd7, 4'b0011);
        check_eq("post_flush_alu", {64'd0, out_alu_result}, 96'h333);
        drain_wait();

`ifdef EX_MEM_PERF_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        send(32'h444, 32'h4, 5'd8, 4'b1000);
        repeat (5) @(negedge clk);
        check_eq("perf_five", {64'd0, stall_cycles}, 96'd5);
        out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("perf_after_flush", {64'd0, stall_cycles}, 96'd5);
        repeat (2) @(negedge clk);
        check_eq("perf_idle", {64'd0, stall_cycles}, 96'd5);
`endif

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        send(32'h777, 32'h7, 5'd9, 4'b1110);
        send(32'h888, 32'h8, 5'd10, 4'b1111);
        check_eq("prerst_in_ready", {95'd0, in_ready}, 96'd0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            in_valid      = 1'($urandom_range(0, 1));
            out_ready     = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 15) == 0);
            in_alu_result = $urandom;
            in_store_data = $urandom;
            in_dest_reg   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            {in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg} = 4'($urandom);
            @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0;
        drain_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
EX/MEM pipeline boundary register for the MIPS pipeline. It consumes the EX-stage destination-register select result (rt/rd after the RegDst choice), the ALU result, the store data and the memory/write-back control bits, and presents them to the MEM stage.
It is built as a two-entry skid buffer with a valid/ready handshake, so a MEM-stage stall back-pressures EX without a combinational ready path. It also provides a synchronous flush for branch/exception squash.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_W, 5, width of register-file index

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  buffer can accept; registered output
in_alu_result  in  DATA_W  ALU output / memory address
in_store_data  in  DATA_W  rt value for sw
in_dest_reg  in  REG_W  destination register from RegDst mux
in_reg_write  in  1  RegWrite control
in_mem_read  in  1  MemRead control
in_mem_write  in  1  MemWrite control
in_mem_to_reg  in  1  MemtoReg control
out_valid  out  1  entry presented to MEM
out_ready  in  1  MEM consumes this cycle
out_alu_result  out  DATA_W  held ALU result
out_store_data  out  DATA_W  held store data
out_dest_reg  out  REG_W  held destination register
out_reg_write  out  1  held RegWrite, gated by out_valid
out_mem_read  out  1  held MemRead, gated by out_valid
out_mem_write  out  1  held MemWrite, gated by out_valid
out_mem_to_reg  out  1  held MemtoReg

Behaviour:
- Clocking and reset:
  - Single clock clk. Reset rst is asynchronous and active-high.
  - On reset: state=EMPTY, in_ready=1, out_valid=0, all payload and control outputs 0.
- Handshake:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - Outputs are driven only from the main entry, never combinationally from the inputs.
  - Minimum latency is 1 cycle from accept to out_valid.
- States and transitions (skid entry used only in FULL):
  - EMPTY: accept -> ONE, main<=in.
  - ONE, accept & drain -> ONE, main<=in.
  - ONE, accept & !drain -> FULL, skid<=in.
  - ONE, !accept & drain -> EMPTY.
  - ONE, neither -> hold.
  - FULL: drain -> ONE, main<=skid. Otherwise hold. No accept is possible in FULL.
- in_ready is registered and equals 1 exactly when next state != FULL.
- $zero rule: on capture, if in_dest_reg == 0 then the stored reg_write is forced 0. All other fields are stored unmodified.
- Output gating: out_reg_write, out_mem_read and out_mem_write are 0 whenever out_valid=0. Payload outputs hold their last value when invalid.
- Flush:
  - Next state is EMPTY and in_ready becomes 1. Flush has priority over accept and drain.
  - A drain in the flush cycle is still a completed transfer, since MEM sees out_valid that cycle.
  - Data accepted in the flush cycle is discarded.
- Reset mid-operation: entries are dropped immediately and outputs follow the reset values above.
- No data is ever duplicated or reordered. Order is FIFO, main before skid.

Optional Feature:
Macro EX_MEM_PERF_CNT_EN.
- When defined: adds output stall_cycles [31:0].
  - Increments every cycle with out_valid & !out_ready, saturating at 32'hFFFFFFFF.
  - Cleared only by rst; unaffected by flush.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package mips_pipe_pkg:
  - Constants DATA_W=32 and REG_W=5.
  - Struct ex_mem_ctrl_t {reg_write, mem_read, mem_write, mem_to_reg}.
  - Struct ex_mem_payload_t {alu_result, store_data, dest_reg, ctrl}.
  - State enum {EMPTY, ONE, FULL}.
- Sub-module ex_mem_entry_reg: payload register with load enable and async reset, instanced twice (main and skid).

Test Plan:
- Reset then idle: rst pulse -> in_ready=1, out_valid=0, all outputs 0. Assert rst mid-FULL -> same values immediately, without waiting for a clock edge.
- Single pass: accept {alu=0x10, dest=2, reg_write=1} with out_ready=1 -> next cycle out_valid=1, out_dest_reg=2, out_alu_result=0x10.
- Back-pressure:
  - Setup: out_ready=0, then accept A(dest=1) and B(dest=2) back-to-back.
  - Response: FULL with in_ready=0; C is held off. Raise out_ready -> A, B, C emerge in order with no loss or duplicate.
- $zero write: accept dest=0, reg_write=1 -> out_reg_write=0, out_dest_reg=0.
- Flush in FULL with simultaneous in_valid -> next cycle out_valid=0, in_ready=1, and the incoming entry does not appear.
- EX_MEM_PERF_CNT_EN defined: hold out_valid=1 with out_ready=0 for 5 cycles -> stall_cycles=5. Flush -> still 5.
